tiny_dnn_unpool: RTL and testbench
==================================

Name: tiny_dnn_unpool

Overview:
Backward-pass max-unpool stage, directly downstream of the 2x2 max-pool stage.
- Consumes the per-window gradient stream, each beat paired with the pool stage's position word pp.
- Rebuilds the dense gradient map of the pool input in external scratch RAM: zero everywhere except the argmax position of each window.
- Works in two phases: a zero-clear sweep, then a scatter of gradients to the pp addresses.

Parameters:
AW, 16, write-address width; pp is interpreted as an AW-bit linear address.
DW, 16, gradient word width (16-bit float, opaque to this block).

Ports:
clk  in  1  clock
xrst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins an unpool job; ignored while busy
ow  in  5  pooled output width (input map width = 2*ow)
oh  in  5  pooled output height (input map height = 2*oh)
in_valid  in  1  gradient beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
pp  in  AW  linear input-map address of the window argmax
gd  in  DW  gradient value for that window
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky: an accepted pp was out of range
wr_en  out  1  RAM write strobe
wr_addr  out  AW  RAM write address
wr_data  out  DW  RAM write data

Behaviour:
- Reset (xrst=0 at a clk edge):
  - FSM goes to IDLE.
  - busy, done, err, in_ready, wr_en, wr_addr and wr_data all become 0.
  - Applies mid-job too: the job is abandoned with no further writes.
- Derived constants, latched at start:
  - NB = ow*oh (beats expected).
  - NW = 4*ow*oh (map words), computed at AW width; maximum 3844.
- FSM states: IDLE, CLEAR, SCATTER, FIN.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with NB!=0 -> CLEAR. start=1 with NB==0 -> FIN, with no writes.
  - start clears err.
- CLEAR:
  - busy=1, in_ready=0.
  - One write per cycle: wr_addr=0,1,...,NW-1, wr_data=0, wr_en=1. The first write appears the cycle after start.
  - After address NW-1 is issued -> SCATTER.
  - Exactly NW cycles; in_valid is ignored (not accepted).
- SCATTER:
  - busy=1, in_ready=1 until NB beats have been accepted, then in_ready=0.
  - Each accepted beat registers wr_en=1, wr_addr=pp, wr_data=gd on the next cycle (latency 1).
  - Beat with pp >= NW: that write is suppressed (wr_en=0), err is set, and the beat still counts.
  - Bubbles (in_valid=0) produce wr_en=0 and no count change.
  - When beat NB is accepted -> FIN.
- FIN:
  - done=1 for exactly one cycle. This coincides with the write of the last beat; for NB==0 it is the cycle after start.
  - busy stays 1 in FIN, then IDLE next cycle.
- start while busy: ignored, no effect on counters.
- start in the same cycle as the final beat: ignored.
- wr_en is 0 in every cycle not listed above.
- ow and oh are sampled only at start; later changes have no effect on the running job.
- Address counter wraps nowhere: its range is bounded by NW <= 3844 < 2^AW.

Decomposition:
- Package tiny_dnn_pkg:
  - enum unpool_state_t {IDLE, CLEAR, SCATTER, FIN}.
  - localparam UNPOOL_AW=16.
  - function map_words(ow,oh) returning 4*ow*oh.
- Single module; no sub-module. The clear counter and beat counter are simple registers inside the block.

Test Plan:
- ow=2, oh=1, start:
  - 8 clear writes at addr 0..7, data 0.
  - Beats (pp=5, gd=16'h3C00) and (pp=2, gd=16'hBC00) -> writes addr5=3C00 and addr2=BC00.
  - done pulses with the second write; err=0.
- ow=1, oh=1, in_valid held high during CLEAR: no beat is taken before the 4th clear write. The first beat (pp=3, gd=16'h4000) is written the cycle after SCATTER accepts it.
- ow=2, oh=2, beat with pp=16 (==NW): no write for that beat, err=1 and stays 1 through done. Next start -> err=0.
- ow=0, oh=3, start: no wr_en at all; done pulses the cycle after start; busy high for exactly 1 cycle.
- ow=3, oh=3: xrst=0 at the 10th clear cycle -> all outputs 0 next cycle. A fresh start then clears addr 0..35 from 0.
- ow=2, oh=2: random in_valid bubbles, plus start re-pulsed mid-SCATTER -> exactly 4 scatter writes, a single done, and the job length is unchanged.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types and helpers for the tiny_dnn backward-pass stages.
package tiny_dnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCATTER,
    FIN
  } unpool_state_t;

  localparam int UNPOOL_AW = 16;

  // Number of words in the un-pooled (2x2 expanded) gradient map.
  function automatic logic [UNPOOL_AW-1:0] map_words(input logic [4:0] ow,
                                                     input logic [4:0] oh);
    logic [UNPOOL_AW-1:0] prod;
    prod = UNPOOL_AW'(ow) * UNPOOL_AW'(oh);
    return prod << 2;
  endfunction

endpackage

// File: rtl/tiny_dnn_unpool.sv
// Max-unpool backward stage: zero-clears the dense gradient map in scratch
// RAM, then scatters each window gradient to its argmax address pp.
import tiny_dnn_pkg::*;

module tiny_dnn_unpool #(
  parameter int AW = UNPOOL_AW,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          start,
  input  logic [4:0]    ow,
  input  logic [4:0]    oh,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] pp,
  input  logic [DW-1:0] gd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  unpool_state_t state_q, state_d;
  logic [AW-1:0] nb_q, nb_d;
  logic [AW-1:0] nw_q, nw_d;
  logic [AW-1:0] beats_q, beats_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          accept;

  assign in_ready = (state_q == SCATTER) && (beats_q < nb_q);
  assign accept   = in_ready && in_valid;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Next-state logic; the clear sweep reuses wr_addr_q as its address counter.
  always_comb begin
    state_d   = state_q;
    nb_d      = nb_q;
    nw_d      = nw_q;
    beats_d   = beats_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nb_d    = AW'(ow) * AW'(oh);
          nw_d    = AW'(map_words(ow, oh));
          beats_d = '0;
          err_d   = 1'b0;
          if ((ow == 5'd0) || (oh == 5'd0)) begin
            state_d = FIN;
          end else begin
            state_d   = CLEAR;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = '0;
          end
        end
      end
      CLEAR: begin
        if (wr_addr_q == nw_q - AW'(1)) begin
          state_d = SCATTER;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + AW'(1);
          wr_data_d = '0;
        end
      end
      SCATTER: begin
        if (accept) begin
          beats_d = beats_q + AW'(1);
          if (pp < nw_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pp;
            wr_data_d = gd;
          end else begin
            err_d = 1'b1;
          end
          if (beats_q + AW'(1) == nb_q) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q   <= IDLE;
      nb_q      <= '0;
      nw_q      <= '0;
      beats_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      nb_q      <= nb_d;
      nw_q      <= nw_d;
      beats_q   <= beats_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_tiny_dnn_unpool.sv
// Self-checking bench for tiny_dnn_unpool: a cycle-indexed job model plus a
// dense-map model, compared against the DUT on every cycle.
module tb_tiny_dnn_unpool;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ow = '0;
  logic [4:0]  oh = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] pp = '0;
  logic [15:0] gd = '0;
  logic        busy, done, err, wr_en;
  logic [15:0] wr_addr, wr_data;

  int errors = 0;
  int checks = 0;

  tiny_dnn_unpool #(.AW(16), .DW(16)) dut (
    .clk(clk), .xrst(xrst), .start(start), .ow(ow), .oh(oh),
    .in_valid(in_valid), .in_ready(in_ready), .pp(pp), .gd(gd),
    .busy(busy), .done(done), .err(err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scratch RAM image as written by the DUT, and the expected dense map.
  logic [15:0] ram [0:4095];
  logic [15:0] exp_map [0:4095];

  int job_writes = 0;
  int job_dones = 0;
  int job_busy = 0;

  // Model of the current job, indexed by cycles since start.
  bit          armed = 0;
  bit          act = 0;
  bit          post_rst = 0;
  bit          m_err = 0;
  bit          fin_next = 0;
  bit          pend_en = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] pend_data = '0;
  int          t = 0;
  int          m_nb = 0;
  int          m_nw = 0;
  int          m_beats = 0;

  // Compare DUT outputs with the model mid-cycle, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    bit          e_done, e_rdy, e_wen;
    logic [15:0] e_addr, e_data;
    int          bad;
    e_done = 0; e_rdy = 0; e_wen = 0; e_addr = '0; e_data = '0;
    if (act) begin
      if (m_nb == 0) begin
        e_done = 1;
      end else if (t <= m_nw) begin
        e_wen = 1; e_addr = 16'(t - 1); e_data = '0;
      end else begin
        e_wen = pend_en; e_addr = pend_addr; e_data = pend_data;
        e_done = fin_next; e_rdy = (m_beats < m_nb);
      end
    end
    if (armed) begin
      checkOutput("busy", 32'(busy), 32'(act));
      checkOutput("done", 32'(done), 32'(e_done));
      checkOutput("in_ready", 32'(in_ready), 32'(e_rdy));
      checkOutput("wr_en", 32'(wr_en), 32'(e_wen));
      checkOutput("err", 32'(err), 32'(m_err));
      if (e_wen || post_rst) begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(e_addr));
        checkOutput("wr_data", 32'(wr_data), 32'(e_data));
      end
      if (wr_en === 1'b1) begin
        job_writes++;
        if (wr_addr < 16'd4096) ram[wr_addr[11:0]] = wr_data;
      end
      if (done === 1'b1) job_dones++;
      if (busy === 1'b1) job_busy++;
      if (e_done && m_nb > 0) begin
        bad = 0;
        for (int a = 0; a < m_nw; a++) if (ram[a] !== exp_map[a]) bad++;
        checkOutput("map_words_wrong", 32'(bad), 32'd0);
      end
    end
    post_rst = 0;
    if (!xrst) begin
      act = 0; m_err = 0; fin_next = 0; pend_en = 0; post_rst = 1; armed = 1;
    end else if (!act) begin
      if (start) begin
        m_err = 0; m_nb = int'(ow) * int'(oh); m_nw = 4 * m_nb; m_beats = 0;
        t = 1; pend_en = 0; fin_next = 0; act = 1;
        for (int a = 0; a < m_nw; a++) exp_map[a] = '0;
      end
    end else if (e_done) begin
      act = 0;
    end else begin
      t++;
      pend_en = 0;
      if (e_rdy && in_valid) begin
        m_beats++;
        if (int'(pp) < m_nw) begin
          pend_en = 1; pend_addr = pp; pend_data = gd; exp_map[pp[11:0]] = gd;
        end else begin
          m_err = 1;
        end
        if (m_beats == m_nb) fin_next = 1;
      end
    end
  end

  logic [15:0] fix_pp[$];
  logic [15:0] fix_gd[$];

  // Run one job: start it, feed ow*oh beats (bubbles, one optional
  // out-of-range beat, optional re-pulsed start), then wait for idle.
  task automatic applyStimulus(input int w, input int h, input int bad_idx,
                               input int bubble_pct, input int restart_at);
    int nb, nw, sent, guard;
    bit accepted;
    nb = w * h; nw = 4 * nb; sent = 0; guard = 0;
    job_writes = 0; job_dones = 0; job_busy = 0;
    for (int a = 0; a < 4096; a++) ram[a] = 16'hDEAD;
    ow = 5'(w); oh = 5'(h); start = 1'b1;
    step();
    start = 1'b0;
    while (sent < nb && guard < 20000) begin
      ow = 5'($urandom_range(0, 31));
      oh = 5'($urandom_range(0, 31));
      if (sent < fix_pp.size()) begin
        pp = fix_pp[sent]; gd = fix_gd[sent];
      end else if (sent == bad_idx) begin
        pp = 16'(nw + $urandom_range(0, 3)); gd = 16'($urandom);
      end else begin
        pp = 16'($urandom_range(0, nw - 1)); gd = 16'($urandom);
      end
      in_valid = in_ready ? ($urandom_range(0, 99) >= bubble_pct) : 1'b1;
      if (sent == restart_at) start = 1'b1;
      accepted = in_valid && in_ready;
      step();
      start = 1'b0;
      guard++;
      if (accepted) sent++;
    end
    in_valid = 1'b0;
    checkOutput("beats_sent", 32'(sent), 32'(nb));
    guard = 0;
    while (busy !== 1'b0 && guard < 10) begin
      step();
      guard++;
    end
    checkOutput("idle_timeout", 32'(busy), 32'd0);
    fix_pp.delete();
    fix_gd.delete();
  endtask

  initial begin
    int w, h, bad, rs;
    $display("[TB] tiny_dnn_unpool bench start");
    repeat (3) step();
    xrst = 1'b1;
    step();

    // Two beats into an 8-word map.
    fix_pp = '{16'd5, 16'd2};
    fix_gd = '{16'h3C00, 16'hBC00};
    applyStimulus(2, 1, -1, 0, -1);
    checkOutput("t1_ram5", 32'(ram[5]), 32'h3C00);
    checkOutput("t1_ram2", 32'(ram[2]), 32'hBC00);
    checkOutput("t1_ram7", 32'(ram[7]), 32'h0);
    checkOutput("t1_writes", 32'(job_writes), 32'd10);
    checkOutput("t1_dones", 32'(job_dones), 32'd1);
    checkOutput("t1_err", 32'(err), 32'd0);

    // Beat offered throughout the clear sweep.
    fix_pp = '{16'd3};
    fix_gd = '{16'h4000};
    applyStimulus(1, 1, -1, 0, -1);
    checkOutput("t2_ram3", 32'(ram[3]), 32'h4000);
    checkOutput("t2_writes", 32'(job_writes), 32'd5);

    // Out-of-range beat sets sticky err; next start clears it.
    fix_pp = '{16'd16};
    fix_gd = '{16'h1234};
    applyStimulus(2, 2, -1, 0, -1);
    checkOutput("t3_err", 32'(err), 32'd1);
    checkOutput("t3_writes", 32'(job_writes), 32'd19);
    checkOutput("t3_dones", 32'(job_dones), 32'd1);
    applyStimulus(1, 1, -1, 0, -1);
    checkOutput("t3_err_cleared", 32'(err), 32'd0);

    // Empty job.
    applyStimulus(0, 3, -1, 0, -1);
    checkOutput("t4_writes", 32'(job_writes), 32'd0);
    checkOutput("t4_dones", 32'(job_dones), 32'd1);
    checkOutput("t4_busy_cycles", 32'(job_busy), 32'd1);

    // Reset during the 10th clear cycle, then a fresh job.
    ow = 5'd3; oh = 5'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    xrst = 1'b0;
    step();
    xrst = 1'b1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_wr_en", 32'(wr_en), 32'd0);
    checkOutput("t5_wr_addr", 32'(wr_addr), 32'd0);
    applyStimulus(3, 3, -1, 0, -1);
    checkOutput("t5_writes", 32'(job_writes), 32'd45);
    checkOutput("t5_dones", 32'(job_dones), 32'd1);

    // Bubbles plus a start re-pulsed mid-scatter.
    applyStimulus(2, 2, -1, 40, 2);
    checkOutput("t6_writes", 32'(job_writes), 32'd20);
    checkOutput("t6_dones", 32'(job_dones), 32'd1);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      w = $urandom_range(0, 5);
      h = $urandom_range(0, 5);
      bad = ($urandom_range(0, 1) == 1 && w * h > 0) ? $urandom_range(0, w * h - 1) : -1;
      rs = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, w * h);
      applyStimulus(w, h, bad, 30, rs);
      checkOutput("rnd_writes", 32'(job_writes), 32'(4 * w * h + w * h - (bad >= 0 ? 1 : 0)));
      checkOutput("rnd_dones", 32'(job_dones), 32'd1);
      checkOutput("rnd_err", 32'(err), 32'(bad >= 0 ? 1 : 0));
    end

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
